id_issue_stage: RTL and testbench
=================================

# id_issue_stage

Registered RV32I decode/issue stage between IF/ID and EX with valid/ready handshakes on both sides, N-port operand forwarding, and load-use hazard stalling. It can resolve branches and jumps in decode, with wrong-path shadow kill, and it keeps a hazard performance counter. Outputs are fully registered and feed EX directly.

## Interface
Parameters:
- FWD_PORTS, 2: number of forwarding sources. Port 0 has the highest priority and is nearest EX.
- BR_IN_ID, 1:
  - 1: branches and jumps are resolved here.
  - 0: they are passed to EX and br_taken stays 0.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- flush_i, in, 1: external pipeline flush.
- in_valid / in_ready, in / out, 1: upstream handshake.
- in_pc, in, 32: PC of the presented instruction.
- in_inst, in, 32: the presented instruction.
- rf_raddr1 / rf_raddr2, out, 5: register-file read addresses, combinational, equal to in_inst[19:15] and in_inst[24:20].
- rf_rdata1 / rf_rdata2, in, 32: register-file read data, same cycle.
- fwd_valid, in, FWD_PORTS: forwarding source i writes a register.
- fwd_rd, in, 5*FWD_PORTS: destination of source i.
- fwd_data, in, 32*FWD_PORTS: result of source i.
- fwd_pending, in, FWD_PORTS: the result of source i is not yet available (load in EX).
- out_valid / out_ready, out / in, 1: downstream handshake.
- out_opcode, out, 7; out_func3, out, 3; out_func7, out, 7: decoded instruction fields.
- out_op1, out_op2, out_store_data, out_imm, out, 32 each: operands.
- out_rd, out, 5; out_wreg, out, 1; out_illegal, out, 1: destination, write enable, illegal-opcode flag.
- br_taken, out, 1; br_target, out, 32: redirect to IF.
- hazard_cnt, out, 32: saturating count of load-use stall cycles.

## Operation
Handshake terms:
- fire = in_valid & in_ready.
- out_adv = !out_valid | out_ready.

Operand resolution for rs1 and rs2, independently:
- Address x0 gives 0 and is never forwarded and never hazards.
- Otherwise the lowest-index port i with fwd_valid[i] & fwd_rd[i]==rs is selected.
  - If fwd_pending[i] is set, this is a hazard.
  - Otherwise the value is fwd_data[i].
- With no matching port, the value is rf_rdata.
- A hazard counts only if the opcode actually reads that register:
  - rs1: R, I, L, S, B, JALR.
  - rs2: R, S, B.

Operand selection:
- R: op1=rs1, op2=rs2.
- I, L: op1=rs1, op2=imm.
- S: op1=rs1, op2=imm, store_data=rs2.
- B: op1=rs1, op2=rs2.
- LUI: op1=0, op2=imm.
- AUIPC: op1=pc, op2=imm.
- JAL, JALR: op1=pc, op2=4 (link value).

Immediates:
- I/L/JALR: sign-extended inst[31:20].
- Shift-immediates (func3 001 or 101): {27'b0, inst[24:20]}.
- S: {inst[31:25], inst[11:7]}, sign-extended.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
- U: {inst[31:12], 12'b0}.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.

Write enable and illegal flag:
- wreg=1 for R, I, L, LUI, AUIPC, JAL, JALR when rd≠0.
- For any other opcode: illegal=1, wreg=0.
- inst==0 is a bubble: it is consumed and out_valid is not set.

Branch resolution (BR_IN_ID=1):
- BEQ/BNE: equality.
- BLT/BGE: signed compare.
- BLTU/BGEU: unsigned compare.
- Taken target = pc + imm. JAL = pc + imm. JALR = (rs1 + imm) & ~1.
- Not-taken branches produce no redirect.
- On the fire of a taken branch or jump, br_taken is registered to 1 for exactly one cycle, with br_target.
- During that cycle (shadow), in_ready=1 and any presented instruction is discarded.

Flush: flush_i clears out_valid and br_taken next cycle. The input is discarded that cycle with in_ready=1. Priority: rst > flush_i > shadow > hazard > normal.

## Timing
- in_ready = shadow | flush_i | (out_adv & !hazard).
- Operand capture happens at the edge where fire is true.
  - Outputs update at that edge, so latency is 1 cycle from fire.
- When out_adv is true, out_valid is updated as follows:
  - fire with a live instruction sets it to 1.
  - A hazard, a bubble, a discarded instruction, or no input sets it to 0 (a bubble is inserted).
- While out_valid & !out_ready, all outputs hold stable.
- hazard_cnt increments each cycle hazard & in_valid & !flush_i & !shadow, and saturates at 0xFFFFFFFF.
- A hazard clears when fwd_pending drops or the producer moves to a non-pending port. The instruction is then accepted that same cycle with the forwarded value.
- Reset values: out_valid=0, br_taken=0, br_target=0, all out_* data=0, out_illegal=0, hazard_cnt=0, shadow=0.
- Reset mid-stall or during shadow aborts everything; in_ready=0 while rst=1.

## Test plan
- ADDI x1,x0,5 followed by ADD x2,x1,x1 with port0 {rd=1, data=5}: second issue has op1=op2=5, out_wreg=1, out_rd=2.
- LW x3 with port0 {rd=3, pending=1} then ADD x4,x3,x0: in_ready=0 for 1 cycle, a bubble is issued, hazard_cnt=1, then op1 = port0 data.
- Both ports match rd=5 (port0 data 0xA, port1 data 0xB): operand is 0xA. rd=0 with fwd_valid=1 and data 7: operand is 0.
- BLT at pc 0x100 with rs1=-1, rs2=1, imm +16: br_taken=1 for 1 cycle, br_target=0x110, the next instruction is discarded. BLTU with the same operands does not redirect.
- JALR at pc 0x40 with rs1=0x203, imm 0: br_target=0x202, op1=0x40, op2=4.
- out_ready=0 for 3 cycles with out_valid=1: outputs stable and in_ready=0. Then flush_i=1: next cycle out_valid=0.

Source files
------------

// File: rtl/id_issue_stage.sv
// RV32I decode/issue stage: operand forwarding, load-use stall, in-decode
// branch resolution with one-cycle wrong-path shadow, hazard stall counter.

// Per-operand forwarding select: lowest-index matching port wins, x0 is hardwired.
module id_fwd_sel #(
  parameter int FWD_PORTS = 2
) (
  input  logic [4:0]                  rs,
  input  logic [31:0]                 rf_rdata,
  input  logic [FWD_PORTS-1:0]        fwd_valid,
  input  logic [FWD_PORTS-1:0][4:0]   fwd_rd,
  input  logic [FWD_PORTS-1:0][31:0]  fwd_data,
  input  logic [FWD_PORTS-1:0]        fwd_pending,
  output logic [31:0]                 val,
  output logic                        pend
);
  // Scan high to low so the lowest-index match overwrites the rest.
  always_comb begin
    val  = rf_rdata;
    pend = 1'b0;
    for (int i = FWD_PORTS-1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[i] == rs) begin
        val  = fwd_data[i];
        pend = fwd_pending[i];
      end
    end
    if (rs == 5'd0) begin
      val  = '0;
      pend = 1'b0;
    end
  end
endmodule

module id_issue_stage #(
  parameter int FWD_PORTS = 2,
  parameter bit BR_IN_ID  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_pc,
  input  logic [31:0]                 in_inst,
  output logic [4:0]                  rf_raddr1,
  output logic [4:0]                  rf_raddr2,
  input  logic [31:0]                 rf_rdata1,
  input  logic [31:0]                 rf_rdata2,
  input  logic [FWD_PORTS-1:0]        fwd_valid,
  input  logic [FWD_PORTS-1:0][4:0]   fwd_rd,
  input  logic [FWD_PORTS-1:0][31:0]  fwd_data,
  input  logic [FWD_PORTS-1:0]        fwd_pending,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [6:0]                  out_opcode,
  output logic [2:0]                  out_func3,
  output logic [6:0]                  out_func7,
  output logic [31:0]                 out_op1,
  output logic [31:0]                 out_op2,
  output logic [31:0]                 out_store_data,
  output logic [31:0]                 out_imm,
  output logic [4:0]                  out_rd,
  output logic                        out_wreg,
  output logic                        out_illegal,
  output logic                        br_taken,
  output logic [31:0]                 br_target,
  output logic [31:0]                 hazard_cnt
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [1:0][4:0]  rs;
  logic [1:0][31:0] rv;
  logic [1:0]       rpend;
  logic [31:0]      imm, op1, op2, sdata, tgt;
  logic             use1, use2, legal, wr, take, cmp;
  logic             hazard, shadow, out_adv, fire, acc_live;

  assign opcode    = in_inst[6:0];
  assign f3        = in_inst[14:12];
  assign rs[0]     = in_inst[19:15];
  assign rs[1]     = in_inst[24:20];
  assign rf_raddr1 = rs[0];
  assign rf_raddr2 = rs[1];

  for (genvar g = 0; g < 2; g++) begin : g_src
    id_fwd_sel #(.FWD_PORTS(FWD_PORTS)) u_sel (
      .rs(rs[g]), .rf_rdata(g == 0 ? rf_rdata1 : rf_rdata2),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .fwd_pending(fwd_pending), .val(rv[g]), .pend(rpend[g])
    );
  end

  // Immediate generation by instruction format.
  always_comb begin
    imm = '0;
    case (opcode)
      OP_I:           imm = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, in_inst[24:20]}
                                                           : {{20{in_inst[31]}}, in_inst[31:20]};
      OP_L, OP_JALR:  imm = {{20{in_inst[31]}}, in_inst[31:20]};
      OP_S:           imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      OP_B:           imm = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {in_inst[31:12], 12'b0};
      OP_JAL:         imm = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      default:        imm = '0;
    endcase
  end

  // Operand selection, register usage, legality, branch decision.
  always_comb begin
    op1 = '0; op2 = '0; sdata = '0; use1 = 1'b0; use2 = 1'b0;
    legal = 1'b1; take = 1'b0; tgt = in_pc + imm;
    case (f3)
      3'b000:  cmp = rv[0] == rv[1];
      3'b001:  cmp = rv[0] != rv[1];
      3'b100:  cmp = $signed(rv[0]) <  $signed(rv[1]);
      3'b101:  cmp = $signed(rv[0]) >= $signed(rv[1]);
      3'b110:  cmp = rv[0] <  rv[1];
      3'b111:  cmp = rv[0] >= rv[1];
      default: cmp = 1'b0;
    endcase
    case (opcode)
      OP_R:         begin op1 = rv[0]; op2 = rv[1]; use1 = 1'b1; use2 = 1'b1; end
      OP_I, OP_L:   begin op1 = rv[0]; op2 = imm; use1 = 1'b1; end
      OP_S:         begin op1 = rv[0]; op2 = imm; sdata = rv[1]; use1 = 1'b1; use2 = 1'b1; end
      OP_B:         begin op1 = rv[0]; op2 = rv[1]; use1 = 1'b1; use2 = 1'b1; take = cmp; end
      OP_LUI:       begin op2 = imm; end
      OP_AUIPC:     begin op1 = in_pc; op2 = imm; end
      OP_JAL:       begin op1 = in_pc; op2 = 32'd4; take = 1'b1; end
      OP_JALR:      begin op1 = in_pc; op2 = 32'd4; use1 = 1'b1; take = 1'b1;
                          tgt = (rv[0] + imm) & ~32'd1; end
      default:      legal = 1'b0;
    endcase
    if (!BR_IN_ID) take = 1'b0;
  end

  assign wr       = legal && opcode != OP_S && opcode != OP_B && in_inst[11:7] != 5'd0;
  assign shadow   = br_taken;
  assign hazard   = (use1 & rpend[0]) | (use2 & rpend[1]);
  assign out_adv  = !out_valid | out_ready;
  assign in_ready = !rst & (shadow | flush_i | (out_adv & !hazard));
  assign fire     = in_valid & in_ready;
  assign acc_live = fire & !flush_i & !shadow & (in_inst != 32'd0);

  // Issue payload: captured only when a live instruction is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_opcode <= '0; out_func3 <= '0; out_func7 <= '0; out_op1 <= '0; out_op2 <= '0;
      out_store_data <= '0; out_imm <= '0; out_rd <= '0; out_wreg <= 1'b0; out_illegal <= 1'b0;
    end else if (acc_live) begin
      out_opcode <= opcode; out_func3 <= f3; out_func7 <= in_inst[31:25];
      out_op1 <= op1; out_op2 <= op2; out_store_data <= sdata; out_imm <= imm;
      out_rd <= in_inst[11:7]; out_wreg <= wr; out_illegal <= !legal;
    end
  end

  // Valid, redirect and shadow; flush wins over a held output.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0; br_taken <= 1'b0; br_target <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0; br_taken <= 1'b0;
    end else begin
      if (out_adv) out_valid <= acc_live;
      br_taken <= acc_live & take;
      if (acc_live & take) br_target <= tgt;
    end
  end

  // Saturating count of cycles a real instruction waits on a pending load.
  always_ff @(posedge clk) begin
    if (rst) hazard_cnt <= '0;
    else if (hazard && in_valid && !flush_i && !shadow && hazard_cnt != '1)
      hazard_cnt <= hazard_cnt + 32'd1;
  end
endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: forwarding, load-use stall, branch
// shadow, JALR target, output hold under backpressure, flush.
module tb_id_issue_stage;
  logic             clk = 1'b0, rst, flush_i, in_valid, in_ready, out_ready, out_valid;
  logic [31:0]      in_pc, in_inst, rf_rdata1, rf_rdata2;
  logic [4:0]       rf_raddr1, rf_raddr2, out_rd;
  logic [1:0]       fwd_valid, fwd_pending;
  logic [1:0][4:0]  fwd_rd;
  logic [1:0][31:0] fwd_data;
  logic [6:0]       out_opcode, out_func7;
  logic [2:0]       out_func3;
  logic [31:0]      out_op1, out_op2, out_store_data, out_imm, br_target, hazard_cnt;
  logic             out_wreg, out_illegal, br_taken;
  int               n_cmp = 0, n_err = 0;

  id_issue_stage #(.FWD_PORTS(2), .BR_IN_ID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .fwd_pending(fwd_pending), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_func3(out_func3),
    .out_func7(out_func7), .out_op1(out_op1), .out_op2(out_op2),
    .out_store_data(out_store_data), .out_imm(out_imm), .out_rd(out_rd),
    .out_wreg(out_wreg), .out_illegal(out_illegal), .br_taken(br_taken),
    .br_target(br_target), .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b1; rf_rdata1 = '0; rf_rdata2 = '0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0; fwd_pending = '0;
    tick(); tick();
    present(32'h0, 32'h00500093); #1;
    chk("in_ready_in_rst", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_br_taken", {31'b0, br_taken}, 32'd0);
    chk("rst_hazard_cnt", hazard_cnt, 32'd0);
    chk("rst_op1", out_op1, 32'd0);
    chk("rst_br_target", br_target, 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5; its rs2 field (x5) is pending on port0 but unused -> no stall
    fwd_valid = 2'b01; fwd_rd[0] = 5'd5; fwd_pending = 2'b01; #1;
    chk("addi_no_false_hazard", {31'b0, in_ready}, 32'd1);
    tick();
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    chk("addi_op2", out_op2, 32'd5);
    chk("addi_rd", {27'b0, out_rd}, 32'd1);
    // ADD x2,x1,x1 with port0 {rd=1,data=5}
    fwd_pending = '0; fwd_rd[0] = 5'd1; fwd_data[0] = 32'd5;
    present(32'h4, 32'h00108133); tick();
    chk("add_fwd_op1", out_op1, 32'd5);
    chk("add_fwd_op2", out_op2, 32'd5);
    chk("add_wreg", {31'b0, out_wreg}, 32'd1);
    chk("add_rd", {27'b0, out_rd}, 32'd2);

    // Load-use: LW x3 then ADD x4,x3,x0 with port0 pending
    fwd_valid = '0; present(32'h8, 32'h00002183); tick();
    chk("lw_opcode", {25'b0, out_opcode}, 32'h03);
    fwd_valid = 2'b01; fwd_rd[0] = 5'd3; fwd_pending = 2'b01; fwd_data[0] = 32'h77;
    present(32'hC, 32'h00018233); #1;
    chk("lu_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'b0, out_valid}, 32'd0);
    chk("lu_cnt", hazard_cnt, 32'd1);
    fwd_pending = '0; #1;
    chk("lu_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("lu_issue_valid", {31'b0, out_valid}, 32'd1);
    chk("lu_issue_op1", out_op1, 32'h77);
    chk("lu_cnt_hold", hazard_cnt, 32'd1);

    // Port priority, then x0 never forwarded
    fwd_valid = 2'b11; fwd_rd[0] = 5'd5; fwd_rd[1] = 5'd5;
    fwd_data[0] = 32'hA; fwd_data[1] = 32'hB;
    present(32'h10, 32'h00028333); tick();
    chk("fwd_priority", out_op1, 32'hA);
    fwd_valid = 2'b01; fwd_rd[0] = 5'd0; fwd_data[0] = 32'd7; rf_rdata1 = 32'h55;
    present(32'h14, 32'h000003B3); tick();
    chk("x0_zero", out_op1, 32'd0);

    // SRAI x1,x2,3: shift immediate is not sign-extended
    fwd_valid = '0; present(32'h18, 32'h40315093); tick();
    chk("srai_imm", out_imm, 32'd3);
    // Illegal opcode, then a bubble
    present(32'h1C, 32'h0000007F); tick();
    chk("illegal_flag", {31'b0, out_illegal}, 32'd1);
    chk("illegal_wreg", {31'b0, out_wreg}, 32'd0);
    chk("illegal_valid", {31'b0, out_valid}, 32'd1);
    present(32'h20, 32'h0); tick();
    chk("bubble_valid", {31'b0, out_valid}, 32'd0);

    // BLT -1 < 1 taken, then shadow discards the next instruction
    rf_rdata1 = 32'hFFFF_FFFF; rf_rdata2 = 32'd1;
    present(32'h100, 32'h0020C863); tick();
    chk("blt_taken", {31'b0, br_taken}, 32'd1);
    chk("blt_target", br_target, 32'h110);
    chk("blt_valid", {31'b0, out_valid}, 32'd1);
    present(32'h110, 32'h00500093); #1;
    chk("shadow_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("shadow_discard", {31'b0, out_valid}, 32'd0);
    chk("shadow_one_cycle", {31'b0, br_taken}, 32'd0);
    // BLTU FFFFFFFF < 1 unsigned false
    present(32'h100, 32'h0020E863); tick();
    chk("bltu_not_taken", {31'b0, br_taken}, 32'd0);
    chk("bltu_valid", {31'b0, out_valid}, 32'd1);
    chk("bltu_imm", out_imm, 32'h10);

    // JALR x1,0(x3) at 0x40 with x3=0x203
    rf_rdata1 = 32'h203; rf_rdata2 = '0;
    present(32'h40, 32'h000180E7); tick();
    chk("jalr_taken", {31'b0, br_taken}, 32'd1);
    chk("jalr_target", br_target, 32'h202);
    chk("jalr_op1", out_op1, 32'h40);
    chk("jalr_op2", out_op2, 32'd4);
    in_valid = 1'b0; tick();
    chk("jalr_shadow_end", {31'b0, br_taken}, 32'd0);

    // Backpressure hold, then flush
    out_ready = 1'b0; rf_rdata1 = '0;
    present(32'h50, 32'h00500093); tick();
    chk("hold_issue", {31'b0, out_valid}, 32'd1);
    present(32'h54, 32'h00108133);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_imm", out_imm, 32'd5);
      chk("hold_opcode", {25'b0, out_opcode}, 32'h13);
    end
    flush_i = 1'b1; #1;
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
